// File: rtl/controlador_contador_vaivem.sv
// Command-driven bidirectional counter: bounds, mode and tick prescaler are
// loaded once, then the count is started, stopped and cleared on command.
module controlador_contador_vaivem #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic [1:0]       cmd_mode,
  input  logic [DIV_W-1:0] cmd_div,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             running,
  output logic             tick,
  output logic             bound_hit,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, CFG, RUN, DONE} state_e;
  typedef enum logic [1:0] {MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_ONESHOT} mode_e;
  typedef enum logic [1:0] {OP_START, OP_STOP, OP_LOAD, OP_CLEAR} op_e;

  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);

  state_e           state_q;
  mode_e            mode_q;
  logic [WIDTH-1:0] lo_q, hi_q, count_q;
  logic [DIV_W-1:0] div_q, presc_q;
  logic             dir_q, tick_q, bound_q, done_q, err_q;

  logic [WIDTH-1:0] upNext, downNext, startCount_d, stepCount_d;
  logic             startDir_d, stepDir_d, stepBound_d, stepDone_d;
  logic             accept;
  op_e              op;

  assign upNext   = count_q + ONE_W;
  assign downNext = count_q - ONE_W;
  assign accept   = cmd_valid && cmd_ready;
  assign op       = op_e'(cmd_op);

  assign startCount_d = (mode_q == MODE_DOWN) ? hi_q : lo_q;
  assign startDir_d   = (mode_q == MODE_DOWN);

  // Next count for one tick; bound checks come first so nothing over/underflows.
  always_comb begin
    stepCount_d = count_q;
    stepDir_d   = dir_q;
    stepBound_d = 1'b0;
    stepDone_d  = 1'b0;
    case (mode_q)
      MODE_UP: begin
        if (count_q == hi_q) begin
          stepCount_d = lo_q;
          stepBound_d = 1'b1;
        end else begin
          stepCount_d = upNext;
        end
      end
      MODE_DOWN: begin
        if (count_q == lo_q) begin
          stepCount_d = hi_q;
          stepBound_d = 1'b1;
        end else begin
          stepCount_d = downNext;
        end
      end
      MODE_BOUNCE: begin
        if (lo_q == hi_q) begin
          stepBound_d = 1'b1;
        end else if (!dir_q) begin
          if (count_q == hi_q) begin
            stepCount_d = downNext;
            stepDir_d   = 1'b1;
            stepBound_d = 1'b1;
          end else begin
            stepCount_d = upNext;
            if (upNext == hi_q) begin
              stepDir_d   = 1'b1;
              stepBound_d = 1'b1;
            end
          end
        end else begin
          if (count_q == lo_q) begin
            stepCount_d = upNext;
            stepDir_d   = 1'b0;
            stepBound_d = 1'b1;
          end else begin
            stepCount_d = downNext;
            if (downNext == lo_q) begin
              stepDir_d   = 1'b0;
              stepBound_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (count_q == hi_q) begin
          stepDone_d = 1'b1;
        end else begin
          stepCount_d = upNext;
          stepDone_d  = (upNext == hi_q);
        end
      end
    endcase
  end

  // Control FSM; in RUN, STOP and CLEAR take precedence over a pending tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q  <= MODE_BOUNCE;
      lo_q    <= '0;
      hi_q    <= '1;
      div_q   <= '0;
      presc_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      bound_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tick_q  <= 1'b0;
      bound_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            case (op)
              OP_START: begin
                if (state_q == DONE) begin
                  count_q <= startCount_d;
                  dir_q   <= startDir_d;
                end
                presc_q <= '0;
                state_q <= RUN;
              end
              OP_LOAD: begin
                if (cmd_lo > cmd_hi) begin
                  err_q <= 1'b1;
                end else begin
                  lo_q    <= cmd_lo;
                  hi_q    <= cmd_hi;
                  mode_q  <= mode_e'(cmd_mode);
                  div_q   <= cmd_div;
                  state_q <= CFG;
                end
              end
              OP_CLEAR: begin
                count_q <= startCount_d;
                dir_q   <= startDir_d;
                state_q <= IDLE;
              end
              default: ;
            endcase
          end
        end
        CFG: begin
          count_q <= startCount_d;
          dir_q   <= startDir_d;
          state_q <= IDLE;
        end
        RUN: begin
          if (accept && op == OP_STOP) begin
            state_q <= IDLE;
          end else if (accept && op == OP_CLEAR) begin
            count_q <= startCount_d;
            dir_q   <= startDir_d;
            state_q <= IDLE;
          end else begin
            if (accept && op == OP_LOAD) begin
              err_q <= 1'b1;
            end
            if (presc_q == div_q) begin
              presc_q <= '0;
              tick_q  <= 1'b1;
              count_q <= stepCount_d;
              dir_q   <= stepDir_d;
              bound_q <= stepBound_d;
              done_q  <= stepDone_d;
              if (stepDone_d) begin
                state_q <= DONE;
              end
            end else begin
              presc_q <= presc_q + ONE_D;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q != CFG);
  assign running   = (state_q == RUN);
  assign count     = count_q;
  assign dir       = dir_q;
  assign tick      = tick_q;
  assign bound_hit = bound_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
